// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one external asynchronous SRAM between the 6502 bus (read/write)
//   and the ADC capture writer (write-only). CEn/OEn are tied low at the top
//   level and WEn = !sram_oe, so sram_oe is both the write strobe and the
//   enable for the SB_IO output drivers.
//
//   Access sequence: IDLE -> SETUP -> WRITE x WR_PULSE -> HOLD -> IDLE
//                                  -> READ  x RD_WAIT  -> DONE -> IDLE
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   c_req/c_we/c_addr/
//   c_wdata/c_rdata/c_ack  CPU request channel (req held until ack)
//   a_req/a_addr/a_wdata/
//   a_ack                  ADC write channel (req held until ack)
//   sram_addr/sram_oe/
//   sram_dout/sram_din     SRAM pins (address, drive-enable/WE, data out/in)
//   grant                  owner of current/last access, 0=CPU 1=ADC
//   busy                   high whenever an access is in flight
module sram_arbiter #(
  parameter int AW        = 19,
  parameter int RD_WAIT   = 2,
  parameter int WR_PULSE  = 1,
  parameter int CPU_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [15:0]   c_addr,
  input  logic [7:0]    c_wdata,
  output logic [7:0]    c_rdata,
  output logic          c_ack,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic          a_ack,
  output logic [AW-1:0] sram_addr,
  output logic          sram_oe,
  output logic [7:0]    sram_dout,
  input  logic [7:0]    sram_din,
  output logic          grant,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    READ,
    DONE
  } state_t;

  // The phase counter only has to reach (longest phase - 1).
  localparam int CMAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int SW   = $clog2(CPU_BURST + 1);

  localparam logic [CW-1:0] WR_LAST   = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_WAIT - 1);
  localparam logic [SW-1:0] BURST_MAX = SW'(CPU_BURST);

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [SW-1:0] streak_reg;
  logic          we_reg;

  logic          adc_win;
  logic [AW-1:0] c_addr_ext;

  // The CPU keeps priority until it has taken CPU_BURST grants in a row while
  // the ADC was waiting; then the ADC gets exactly one slot.
  assign adc_win    = a_req && (!c_req || (streak_reg == BURST_MAX));
  assign c_addr_ext = {{(AW-16){1'b0}}, c_addr};
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      streak_reg <= '0;
      we_reg     <= 1'b0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_oe    <= 1'b0;
      c_rdata    <= '0;
      c_ack      <= 1'b0;
      a_ack      <= 1'b0;
      grant      <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; the states below raise them.
      c_ack <= 1'b0;
      a_ack <= 1'b0;

      // Fairness only matters while the ADC is actually waiting.
      if (!a_req) begin
        streak_reg <= '0;
      end

      case (state_reg)
        IDLE: begin
          if (c_req || a_req) begin
            grant     <= adc_win;
            we_reg    <= adc_win | c_we;  // ADC accesses are always writes
            sram_addr <= adc_win ? a_addr : c_addr_ext;
            sram_dout <= adc_win ? a_wdata : c_wdata;
            state_reg <= SETUP;
            if (adc_win) begin
              streak_reg <= '0;
            end else if (a_req && (streak_reg != BURST_MAX)) begin
              streak_reg <= streak_reg + 1'b1;
            end
          end
        end

        // One cycle of stable address before WE falls.
        SETUP: begin
          cnt_reg <= '0;
          if (we_reg) begin
            sram_oe   <= 1'b1;
            state_reg <= WRITE;
          end else begin
            state_reg <= READ;
          end
        end

        WRITE: begin
          if (cnt_reg == WR_LAST) begin
            sram_oe   <= 1'b0;
            state_reg <= HOLD;
            if (grant) begin
              a_ack <= 1'b1;
            end else begin
              c_ack <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        // Address/data stay put one cycle after WE rises.
        HOLD: begin
          state_reg <= IDLE;
        end

        READ: begin
          if (cnt_reg == RD_LAST) begin
            c_rdata   <= sram_din;
            c_ack     <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we;
  logic [15:0] c_addr;
  logic [7:0]  c_wdata, c_rdata;
  logic        c_ack;
  logic        a_req;
  logic [18:0] a_addr;
  logic [7:0]  a_wdata;
  logic        a_ack;
  logic [18:0] sram_addr;
  logic        sram_oe;
  logic [7:0]  sram_dout, sram_din;
  logic        grant, busy;

  sram_arbiter #(
    .AW(19), .RD_WAIT(2), .WR_PULSE(1), .CPU_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
    .sram_addr(sram_addr), .sram_oe(sram_oe), .sram_dout(sram_dout),
    .sram_din(sram_din), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter: value during the cycle that follows its posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Small SRAM model (low 10 address bits), 0x200 preloaded with 8'h3C.
  logic [7:0] mem [0:1023];
  bit         preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      mem[10'h200] <= 8'h3C;
      preloaded    <= 1'b1;
    end else if (sram_oe) begin
      mem[sram_addr[9:0]] <= sram_dout;
    end
  end
  assign sram_din = mem[sram_addr[9:0]];

  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;

  typedef struct {
    bit          adc;
    bit          rd;
    logic [7:0]  rdata;
    logic [7:0]  dout;
    logic [18:0] addr;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: whenever an ack appears, pop the oldest expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sram_oe) oe_cnt++;
      if (c_ack || a_ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got c_ack=%0b a_ack=%0b expected none (cycle %0d)",
                   c_ack, a_ack, cyc);
        end else begin
          e = sb.pop_front();
          $display("txn src=%s %s addr=%05h dout=%02h rdata=%02h cycle=%0d",
                   a_ack ? "ADC" : "CPU", e.rd ? "RD" : "WR", sram_addr, sram_dout,
                   c_rdata, cyc);
          chk("ack_c", c_ack, !e.adc);
          chk("ack_a", a_ack, e.adc);
          chk("ack_grant", grant, e.adc);
          chk("ack_addr", sram_addr, e.addr);
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_oe_low", sram_oe, 0);
          if (e.rd) chk("ack_rdata", c_rdata, e.rdata);
          else      chk("ack_dout", sram_dout, e.dout);
        end
      end
    end
  end

  // One complete access on either channel; returns after req is dropped.
  task automatic run_access(input bit adc, input bit we, input logic [18:0] addr,
                            input logic [7:0] wd, input logic [7:0] exp_rd,
                            input bit drop_early);
    exp_t e;
    int   oe0;
    bit   got = 1'b0;
    @(posedge clk); #1;
    oe0 = oe_cnt;
    if (adc) begin
      a_req = 1'b1; a_addr = addr; a_wdata = wd;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr[15:0]; c_wdata = wd;
    end
    e.adc   = adc;
    e.rd    = !adc && !we;
    e.rdata = exp_rd;
    e.dout  = wd;
    e.addr  = adc ? addr : {3'b000, addr[15:0]};
    e.cyc   = cyc + (e.rd ? 4 : 3);
    sb.push_back(e);
    if (drop_early) begin
      @(posedge clk); #1;
      c_req = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c_ack || a_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
    chk("oe_pulse_count", oe_cnt - oe0, e.rd ? 0 : 1);
    @(posedge clk); #1;
    c_req = 1'b0;
    a_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   p;
    int   acks;
    exp_t e;
    reset = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    a_req = 1'b0; a_addr = '0; a_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_oe", sram_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);

    // 1: reset while WE is low aborts the write, no ack.
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0055; c_wdata = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_oe_in_write", sram_oe, 1);
    reset = 1'b1;
    c_req = 1'b0;
    @(negedge clk);
    chk("t1_oe_after_rst", sram_oe, 0);
    chk("t1_c_ack", c_ack, 0);
    chk("t1_addr", sram_addr, 0);
    chk("t1_dout", sram_dout, 0);
    chk("t1_busy", busy, 0);
    chk("t1_grant", grant, 0);
    chk("t1_rdata", c_rdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 2: CPU write, cycle-by-cycle pin checks.
    @(posedge clk); #1;
    p = cyc;
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h1234; c_wdata = 8'hA5;
    e.adc = 0; e.rd = 0; e.rdata = 0; e.dout = 8'hA5; e.addr = 19'h01234; e.cyc = p + 3;
    sb.push_back(e);
    @(negedge clk);
    chk("t2_c0_oe", sram_oe, 0);
    chk("t2_c0_busy", busy, 0);
    @(negedge clk);
    chk("t2_c1_oe", sram_oe, 0);
    chk("t2_c1_addr", sram_addr, 19'h01234);
    chk("t2_c1_dout", sram_dout, 8'hA5);
    chk("t2_c1_busy", busy, 1);
    @(negedge clk);
    chk("t2_c2_oe", sram_oe, 1);
    chk("t2_c2_addr", sram_addr, 19'h01234);
    chk("t2_c2_dout", sram_dout, 8'hA5);
    @(negedge clk);
    chk("t2_c3_oe", sram_oe, 0);
    chk("t2_c3_ack", c_ack, 1);
    chk("t2_c3_dout", sram_dout, 8'hA5);
    @(posedge clk); #1;
    c_req = 1'b0;
    @(negedge clk);
    chk("t2_c4_busy", busy, 0);
    chk("t2_c4_ack", c_ack, 0);

    // 3: CPU read of preloaded 0x0200, then read-back of the test-2 write.
    run_access(0, 0, 19'h00200, 8'hFF, 8'h3C, 0);
    run_access(0, 0, 19'h01234, 8'h00, 8'hA5, 0);
    run_access(0, 0, 19'h00200, 8'h00, 8'h3C, 0);

    // 5: ADC write to top of the address space; c_rdata must hold.
    run_access(1, 1, 19'h7FFFF, 8'h81, 8'h00, 0);
    chk("t5_rdata_hold", c_rdata, 8'h3C);

    // 6: CPU drops req during SETUP; write still completes, single ack.
    run_access(0, 1, 19'h00ABC, 8'h5A, 8'h00, 1);
    repeat (3) @(negedge clk);
    chk("t6_idle", busy, 0);

    // 4: both requesters held; expect C,C,C,C,A,C,C,C,C,A every 4 cycles.
    @(posedge clk); #1;
    p = cyc;
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0010; c_wdata = 8'h11;
    a_req = 1'b1; a_addr = 19'h40005; a_wdata = 8'h99;
    for (int k = 0; k < 10; k++) begin
      e.adc   = (k == 4) || (k == 9);
      e.rd    = 0;
      e.rdata = 0;
      e.dout  = e.adc ? 8'h99 : 8'h11;
      e.addr  = e.adc ? 19'h40005 : 19'h00010;
      e.cyc   = p + 3 + 4 * k;
      sb.push_back(e);
    end
    acks = 0;
    for (int i = 0; i < 60 && acks < 10; i++) begin
      @(negedge clk);
      if (c_ack || a_ack) acks++;
    end
    chk("t4_ack_count", acks, 10);
    @(posedge clk); #1;
    c_req = 1'b0;
    a_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_idle", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
